hub_div_requester: RTL and testbench

HUB_DIV_REQUESTER -- requirements
Module: hub_div_requester

---
 rtl/hub_div_requester.sv | 96 +++++++++
 tb/tb_hub_div_requester.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hub_div_requester.sv
// hub_div_requester: issues one divide at a time to a divider unit, with a WAIT timeout that flushes the unit.
// Ports: clk_i/rst_ni (sync active-low reset); host request req_valid_i/req_ready_o/req_x_i/req_d_i/req_tag_i;
// divider side operands_o/op_o/op_mod_o/in_valid_o/in_ready_i/flush_o/result_i/status_i/out_valid_i/out_ready_o;
// host response resp_valid_o/resp_ready_i/resp_result_o/resp_status_o/resp_tag_o/resp_err_o; busy_o.
module hub_div_requester #(
    parameter int WIDTH   = 16,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [WIDTH-1:0]          req_x_i,
    input  logic [WIDTH-1:0]          req_d_i,
    input  logic [TAG_W-1:0]          req_tag_i,
    output logic [2:0][WIDTH-1:0]     operands_o,
    output logic [3:0]                op_o,
    output logic                      op_mod_o,
    output logic                      in_valid_o,
    input  logic                      in_ready_i,
    output logic                      flush_o,
    input  logic [WIDTH-1:0]          result_i,
    input  logic [4:0]                status_i,
    input  logic                      out_valid_i,
    output logic                      out_ready_o,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [WIDTH-1:0]          resp_result_o,
    output logic [4:0]                resp_status_o,
    output logic [TAG_W-1:0]          resp_tag_o,
    output logic                      resp_err_o,
    output logic                      busy_o
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [3:0] OP_DIV = 4'd4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e            state, state_n;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  x_q, d_q;
    logic [TAG_W-1:0]  tag_q;
    logic              timeout, done;

    // a result arriving on the timeout cycle takes priority over the abort
    assign timeout = state == WAIT && cnt == CW'(TIMEOUT - 1);
    assign done    = state == WAIT && (out_valid_i || timeout);

    assign req_ready_o  = state == IDLE;
    assign in_valid_o   = state == ISSUE;
    assign out_ready_o  = state == WAIT;
    assign flush_o      = timeout && !out_valid_i;
    assign resp_valid_o = state == RESP;
    assign busy_o       = state != IDLE;
    assign operands_o   = {{WIDTH{1'b0}}, d_q, x_q};
    assign op_o         = OP_DIV;
    assign op_mod_o     = 1'b0;
    assign resp_tag_o   = tag_q;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = req_valid_i  ? ISSUE : IDLE;
            ISSUE:   state_n = in_ready_i   ? WAIT  : ISSUE;
            WAIT:    state_n = done         ? RESP  : WAIT;
            default: state_n = resp_ready_i ? IDLE  : RESP;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state         <= IDLE;
            cnt           <= '0;
            x_q           <= '0;
            d_q           <= '0;
            tag_q         <= '0;
            resp_result_o <= '0;
            resp_status_o <= '0;
            resp_err_o    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= state == WAIT ? cnt + CW'(1) : '0;
            if (state == IDLE && req_valid_i) begin
                x_q   <= req_x_i;
                d_q   <= req_d_i;
                tag_q <= req_tag_i;
            end
            if (done) begin
                resp_result_o <= out_valid_i ? result_i : '0;
                resp_status_o <= out_valid_i ? status_i : '0;
                resp_err_o    <= !out_valid_i;
            end
        end
    end
endmodule

// File: tb/tb_hub_div_requester.sv
// tb_hub_div_requester: directed stimulus, cycle-by-cycle comparison against a phase-level behavioural model.
module tb_hub_div_requester;
    localparam int TIMEOUT = 64;

    logic             clk_i = 0, rst_ni = 0;
    logic             req_valid_i = 0, req_ready_o;
    logic [15:0]      req_x_i = 0, req_d_i = 0;
    logic [3:0]       req_tag_i = 0;
    logic [2:0][15:0] operands_o;
    logic [3:0]       op_o;
    logic             op_mod_o, in_valid_o, in_ready_i = 0, flush_o;
    logic [15:0]      result_i = 0;
    logic [4:0]       status_i = 0;
    logic             out_valid_i = 0, out_ready_o;
    logic             resp_valid_o, resp_ready_i = 0;
    logic [15:0]      resp_result_o;
    logic [4:0]       resp_status_o;
    logic [3:0]       resp_tag_o;
    logic             resp_err_o, busy_o;

    hub_div_requester #(.WIDTH(16), .TAG_W(4), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_x_i(req_x_i), .req_d_i(req_d_i), .req_tag_i(req_tag_i),
        .operands_o(operands_o), .op_o(op_o), .op_mod_o(op_mod_o),
        .in_valid_o(in_valid_o), .in_ready_i(in_ready_i), .flush_o(flush_o),
        .result_i(result_i), .status_i(status_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_result_o(resp_result_o), .resp_status_o(resp_status_o),
        .resp_tag_o(resp_tag_o), .resp_err_o(resp_err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0, bad = 0, nflush = 0;
    bit en = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    // Model: ph 0=idle 1=issue 2=wait 3=resp; wcyc is the 1-based index of the current WAIT cycle.
    int          ph = 0, wcyc = 0;
    logic [15:0] m_x = 0, m_d = 0, m_res = 0;
    logic [3:0]  m_tag = 0;
    logic [4:0]  m_st = 0;
    logic        m_err = 0;

    initial forever begin
        @(posedge clk_i);
        if (!rst_ni) begin
            ph = 0; wcyc = 0; m_x = 0; m_d = 0; m_tag = 0; m_res = 0; m_st = 0; m_err = 0;
        end else if (ph == 0) begin
            if (req_valid_i) begin m_x = req_x_i; m_d = req_d_i; m_tag = req_tag_i; ph = 1; end
        end else if (ph == 1) begin
            if (in_ready_i) begin ph = 2; wcyc = 1; end
        end else if (ph == 2) begin
            if (out_valid_i) begin m_res = result_i; m_st = status_i; m_err = 0; ph = 3; end
            else if (wcyc == TIMEOUT) begin m_res = 0; m_st = 0; m_err = 1; ph = 3; end
            else wcyc++;
        end else if (resp_ready_i) ph = 0;
    end

    initial forever begin
        @(negedge clk_i);
        if (en) begin
            chk("req_ready", req_ready_o, ph == 0);
            chk("in_valid", in_valid_o, ph == 1);
            chk("out_ready", out_ready_o, ph == 2);
            chk("flush", flush_o, ph == 2 && wcyc == TIMEOUT && !out_valid_i);
            chk("resp_valid", resp_valid_o, ph == 3);
            chk("busy", busy_o, ph != 0);
            chk("op", op_o, 4);
            chk("op_mod", op_mod_o, 0);
            if (ph == 1) begin
                chk("opnd0", operands_o[0], m_x);
                chk("opnd1", operands_o[1], m_d);
                chk("opnd2", operands_o[2], 0);
            end
            if (ph == 3) begin
                chk("resp_result", resp_result_o, m_res);
                chk("resp_status", resp_status_o, m_st);
                chk("resp_tag", resp_tag_o, m_tag);
                chk("resp_err", resp_err_o, m_err);
            end
            if (flush_o) nflush++;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic request(input logic [15:0] x, input logic [15:0] d, input logic [3:0] t);
        req_valid_i = 1; req_x_i = x; req_d_i = d; req_tag_i = t;
        step();
        req_valid_i = 0; req_x_i = 16'hDEAD; req_d_i = 16'hBEEF; req_tag_i = 4'hF;
    endtask

    task automatic pulse(input logic [15:0] r, input logic [4:0] s);
        out_valid_i = 1; result_i = r; status_i = s;
        step();
        out_valid_i = 0; result_i = 16'h1234; status_i = 5'h1F;
    endtask

    int fk, f0;

    initial begin
        step(2);
        en = 1;
        rst_ni = 1;
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_resp_valid", resp_valid_o, 0);

        // basic divide, result after 10 cycles
        in_ready_i = 1;
        request(16'h3C00, 16'h4000, 4'd3);
        step();
        in_ready_i = 0;
        step(9);
        pulse(16'h3800, 5'h00);
        chk("t1_result", resp_result_o, 16'h3800);
        chk("t1_tag", resp_tag_o, 3);
        chk("t1_err", resp_err_o, 0);
        resp_ready_i = 1; step(); resp_ready_i = 0;
        chk("t1_idle", req_ready_o, 1);

        // stalled issue
        request(16'h4200, 16'h3E00, 4'd5);
        step(5);
        chk("t2_in_valid", in_valid_o, 1);
        chk("t2_opnd0", operands_o[0], 16'h4200);
        chk("t2_opnd1", operands_o[1], 16'h3E00);
        in_ready_i = 1; step(); in_ready_i = 0;
        pulse(16'h4400, 5'h01);
        chk("t2_status", resp_status_o, 5'h01);
        resp_ready_i = 1; step(); resp_ready_i = 0;

        // timeout
        f0 = nflush;
        fk = 0;
        in_ready_i = 1;
        request(16'h3C00, 16'h0000, 4'd9);
        step();
        in_ready_i = 0;
        for (int k = 1; k <= 70; k++) begin
            if (flush_o) begin fk = k; break; end
            step();
        end
        chk("t3_flush_cycle", fk, 64);
        step();
        chk("t3_err", resp_err_o, 1);
        chk("t3_result", resp_result_o, 0);
        chk("t3_tag", resp_tag_o, 9);
        chk("t3_flush_count", nflush - f0, 1);
        resp_ready_i = 1; step(); resp_ready_i = 0;

        // stray pulses outside WAIT, held response
        pulse(16'hFFFF, 5'h1F);
        request(16'h3800, 16'h3C00, 4'd7);
        pulse(16'hEEEE, 5'h1E);
        in_ready_i = 1; step(); in_ready_i = 0;
        step(2);
        pulse(16'h3555, 5'h04);
        step(3);
        pulse(16'h7777, 5'h02);
        step(3);
        chk("t4_result", resp_result_o, 16'h3555);
        chk("t4_tag", resp_tag_o, 7);
        chk("t4_valid", resp_valid_o, 1);
        resp_ready_i = 1; step(); resp_ready_i = 0;
        chk("t4_idle", busy_o, 0);

        // reset during WAIT
        f0 = nflush;
        in_ready_i = 1;
        request(16'h4000, 16'h4000, 4'd2);
        step();
        in_ready_i = 0;
        step(3);
        rst_ni = 0; step(); rst_ni = 1;
        chk("t5_busy", busy_o, 0);
        chk("t5_req_ready", req_ready_o, 1);
        chk("t5_resp_valid", resp_valid_o, 0);
        chk("t5_flush", nflush - f0, 0);
        in_ready_i = 1;
        request(16'h4400, 16'h4000, 4'd4);
        step();
        in_ready_i = 0;
        pulse(16'h4000, 5'h00);
        chk("t5_result", resp_result_o, 16'h4000);
        chk("t5_tag", resp_tag_o, 4);
        resp_ready_i = 1; step(); resp_ready_i = 0;

        // result arriving on the timeout cycle
        f0 = nflush;
        in_ready_i = 1;
        request(16'h3C00, 16'h3C00, 4'd11);
        step();
        in_ready_i = 0;
        step(63);
        out_valid_i = 1; result_i = 16'h4A00; status_i = 5'h08;
        #1;
        chk("t6_flush", flush_o, 0);
        step();
        out_valid_i = 0;
        chk("t6_err", resp_err_o, 0);
        chk("t6_result", resp_result_o, 16'h4A00);
        chk("t6_flush_count", nflush - f0, 0);
        resp_ready_i = 1; step(); resp_ready_i = 0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
